// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO widths, default thresholds and parameter-range check.
package fifo_pkg;
   localparam int FIFO_AE_LEVEL_DEF = 2;
   localparam int FIFO_AF_MARGIN_DEF = 2;
   function automatic int fifo_count_w(input int addr_width);
      return addr_width + 1;
   endfunction
   function automatic logic fifo_params_ok(input int addr_width, input int af_level, input int ae_level);
      return addr_width >= 1 && af_level >= 1 && af_level <= (1 << addr_width) &&
             ae_level >= 0 && ae_level < (1 << addr_width);
   endfunction
endpackage

// File: rtl/fifo_sync_nbit_if.sv
// fifo_sync_nbit_if: write/read handshake, status and error bundle of the sync FIFO.
interface fifo_sync_nbit_if #(
   parameter int data_width = 8,
   parameter int addr_width = 4
);
   logic                  write;
   logic [data_width-1:0] write_data;
   logic                  write_full;
   logic                  write_almost_full;
   logic                  read;
   logic [data_width-1:0] read_data;
   logic                  read_empty;
   logic                  read_almost_empty;
   logic [addr_width:0]   count;
   logic                  overflow;
   logic                  underflow;
   modport master (
      output write, write_data, read,
      input  write_full, write_almost_full, read_data, read_empty, read_almost_empty,
             count, overflow, underflow
   );
   modport slave (
      input  write, write_data, read,
      output write_full, write_almost_full, read_data, read_empty, read_almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_mem.sv
// fifo_sync_mem: depth x data_width storage, synchronous write, asynchronous read, no reset.
module fifo_sync_mem #(
   parameter int data_width = 8,
   parameter int addr_width = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [addr_width-1:0] waddr,
   input  logic [data_width-1:0] wdata,
   input  logic [addr_width-1:0] raddr,
   output logic [data_width-1:0] rdata
);
   logic [data_width-1:0] mem [1 << addr_width];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_nbit.sv
// fifo_sync_nbit: single-clock FIFO with thresholds, occupancy count and sticky errors.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; otherwise read_data is registered.
module fifo_sync_nbit import fifo_pkg::*; #(
   parameter int data_width = 8,
   parameter int addr_width = 4,
   parameter int af_level   = (1 << addr_width) - FIFO_AF_MARGIN_DEF,
   parameter int ae_level   = FIFO_AE_LEVEL_DEF
) (
   input logic             clk,
   input logic             rst,
   fifo_sync_nbit_if.slave bus
);
   localparam int cw = fifo_count_w(addr_width);
   localparam logic [cw-1:0] depth_c = cw'(1 << addr_width);
   localparam logic [cw-1:0] af_c = cw'(af_level);
   localparam logic [cw-1:0] ae_c = cw'(ae_level);

   if (!fifo_params_ok(addr_width, af_level, ae_level)) begin : g_bad_params
      $error("fifo_sync_nbit: illegal addr_width/af_level/ae_level");
   end

   logic [addr_width-1:0] wr_ptr, rd_ptr;
   logic [cw-1:0]         cnt;
   logic                  wr_acc, rd_acc, ovf, udf;
   logic [data_width-1:0] head;

   // Acceptance uses the pre-edge count: no pass-through when full or empty.
   assign wr_acc = bus.write && !bus.write_full;
   assign rd_acc = bus.read && !bus.read_empty;

   fifo_sync_mem #(.data_width(data_width), .addr_width(addr_width)) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (bus.write_data),
      .raddr (rd_ptr),
      .rdata (head)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + addr_width'(wr_acc);
         rd_ptr <= rd_ptr + addr_width'(rd_acc);
         cnt    <= cnt + cw'(wr_acc) - cw'(rd_acc);
         ovf    <= ovf | (bus.write & bus.write_full);
         udf    <= udf | (bus.read & bus.read_empty);
      end

   assign bus.count             = cnt;
   assign bus.write_full        = cnt == depth_c;
   assign bus.write_almost_full = cnt >= af_c;
   assign bus.read_empty        = cnt == '0;
   assign bus.read_almost_empty = cnt <= ae_c;
   assign bus.overflow          = ovf;
   assign bus.underflow         = udf;

`ifdef FIFO_SYNC_FWFT_EN
   assign bus.read_data = bus.read_empty ? '0 : head;
`else
   logic [data_width-1:0] rd_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) rd_q <= '0;
      else if (rd_acc) rd_q <= head;
   assign bus.read_data = rd_q;
`endif
endmodule

// File: tb/tb_fifo_sync_nbit.sv
// tb_fifo_sync_nbit: directed checks of fill, drain, simultaneous access, reset and FWFT.
module tb_fifo_sync_nbit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int compared = 0;
   int mismatched = 0;

   fifo_sync_nbit_if #(.data_width(8), .addr_width(2)) bus ();

   fifo_sync_nbit #(.data_width(8), .addr_width(2), .af_level(3), .ae_level(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [7:0] wd, input logic r);
      bus.write = w;
      bus.write_data = wd;
      bus.read = r;
   endtask

   task automatic test_reset();
      drive(0, 8'h00, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      compared++; if (bus.count !== 3'd0) begin mismatched++; $display("FAIL por_count got %0d want 0", bus.count); end
      compared++; if (bus.read_empty !== 1'b1 || bus.read_almost_empty !== 1'b1) begin mismatched++; $display("FAIL por_empty got %b%b want 11", bus.read_empty, bus.read_almost_empty); end
      compared++; if (bus.write_full !== 1'b0 || bus.write_almost_full !== 1'b0) begin mismatched++; $display("FAIL por_full got %b%b want 00", bus.write_full, bus.write_almost_full); end
      compared++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.read_data !== 8'h00) begin mismatched++; $display("FAIL por_err got %b%b data %h want 00 data 00", bus.overflow, bus.underflow, bus.read_data); end
      for (int i = 1; i <= 3; i++) begin
         drive(1, 8'(i), 0);
         tick();
      end
      drive(1, 8'h04, 1);
      tick();
      drive(0, 8'h00, 0);
      compared++; if (bus.count !== 3'd3) begin mismatched++; $display("FAIL pre_rst_count got %0d want 3", bus.count); end
`ifdef FIFO_SYNC_FWFT_EN
      compared++; if (bus.read_data !== 8'h02) begin mismatched++; $display("FAIL pre_rst_data got %h want 02", bus.read_data); end
`else
      compared++; if (bus.read_data !== 8'h01) begin mismatched++; $display("FAIL pre_rst_data got %h want 01", bus.read_data); end
`endif
      #2 rst = 1'b1;
      #1;
      compared++; if (bus.count !== 3'd0) begin mismatched++; $display("FAIL async_rst_count got %0d want 0", bus.count); end
      compared++; if (bus.read_empty !== 1'b1 || bus.read_almost_empty !== 1'b1 || bus.write_full !== 1'b0) begin mismatched++; $display("FAIL async_rst_flags got e%b ae%b f%b want e1 ae1 f0", bus.read_empty, bus.read_almost_empty, bus.write_full); end
      compared++; if (bus.read_data !== 8'h00 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin mismatched++; $display("FAIL async_rst_data got %h o%b u%b want 00 o0 u0", bus.read_data, bus.overflow, bus.underflow); end
      #1 rst = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'hA1 + 8'(i), 0);
         tick();
         compared++; if (bus.count !== 3'(i + 1)) begin mismatched++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.count, i + 1); end
         compared++; if (bus.write_almost_full !== (i >= 2)) begin mismatched++; $display("FAIL fill_af[%0d] got %b want %b", i, bus.write_almost_full, i >= 2); end
         compared++; if (bus.write_full !== (i == 3)) begin mismatched++; $display("FAIL fill_full[%0d] got %b want %b", i, bus.write_full, i == 3); end
      end
      drive(1, 8'hA5, 0);
      tick();
      drive(0, 8'h00, 0);
      compared++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin mismatched++; $display("FAIL fill_overflow got o%b c%0d want o1 c4", bus.overflow, bus.count); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
`ifdef FIFO_SYNC_FWFT_EN
         compared++; if (bus.read_data !== 8'hA1 + 8'(i)) begin mismatched++; $display("FAIL drain_head[%0d] got %h want %h", i, bus.read_data, 8'hA1 + 8'(i)); end
         drive(0, 8'h00, 1);
         tick();
`else
         drive(0, 8'h00, 1);
         tick();
         compared++; if (bus.read_data !== 8'hA1 + 8'(i)) begin mismatched++; $display("FAIL drain_data[%0d] got %h want %h", i, bus.read_data, 8'hA1 + 8'(i)); end
`endif
         compared++; if (bus.count !== 3'(3 - i)) begin mismatched++; $display("FAIL drain_count[%0d] got %0d want %0d", i, bus.count, 3 - i); end
         compared++; if (bus.read_almost_empty !== (i >= 2)) begin mismatched++; $display("FAIL drain_ae[%0d] got %b want %b", i, bus.read_almost_empty, i >= 2); end
      end
      compared++; if (bus.read_empty !== 1'b1 || bus.underflow !== 1'b0) begin mismatched++; $display("FAIL drain_empty got e%b u%b want e1 u0", bus.read_empty, bus.underflow); end
      tick();
      drive(0, 8'h00, 0);
`ifdef FIFO_SYNC_FWFT_EN
      compared++; if (bus.underflow !== 1'b1 || bus.read_data !== 8'h00) begin mismatched++; $display("FAIL drain_underflow got u%b d%h want u1 d00", bus.underflow, bus.read_data); end
`else
      compared++; if (bus.underflow !== 1'b1 || bus.read_data !== 8'hA4) begin mismatched++; $display("FAIL drain_underflow got u%b d%h want u1 dA4", bus.underflow, bus.read_data); end
`endif
      compared++; if (bus.overflow !== 1'b1 || bus.count !== 3'd0) begin mismatched++; $display("FAIL drain_sticky got o%b c%0d want o1 c0", bus.overflow, bus.count); end
   endtask

   task automatic test_simultaneous();
      rst = 1'b1;
      #1 rst = 1'b0;
      drive(1, 8'h10, 0);
      tick();
      drive(1, 8'h11, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 8'h12 + 8'(i), 1);
`ifdef FIFO_SYNC_FWFT_EN
         compared++; if (bus.read_data !== 8'h10 + 8'(i)) begin mismatched++; $display("FAIL simul_head[%0d] got %h want %h", i, bus.read_data, 8'h10 + 8'(i)); end
         tick();
`else
         tick();
         compared++; if (bus.read_data !== 8'h10 + 8'(i)) begin mismatched++; $display("FAIL simul_data[%0d] got %h want %h", i, bus.read_data, 8'h10 + 8'(i)); end
`endif
         compared++; if (bus.count !== 3'd2) begin mismatched++; $display("FAIL simul_count[%0d] got %0d want 2", i, bus.count); end
      end
      drive(1, 8'h1A, 0);
      tick();
      drive(1, 8'h1B, 0);
      tick();
      compared++; if (bus.write_full !== 1'b1 || bus.overflow !== 1'b0) begin mismatched++; $display("FAIL simul_prefull got f%b o%b want f1 o0", bus.write_full, bus.overflow); end
      drive(1, 8'h1C, 1);
      tick();
      compared++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1) begin mismatched++; $display("FAIL simul_full got c%0d o%b want c3 o1", bus.count, bus.overflow); end
`ifndef FIFO_SYNC_FWFT_EN
      compared++; if (bus.read_data !== 8'h18) begin mismatched++; $display("FAIL simul_full_data got %h want 18", bus.read_data); end
`endif
      drive(0, 8'h00, 0);
      rst = 1'b1;
      #1 rst = 1'b0;
      drive(1, 8'h33, 1);
      tick();
      compared++; if (bus.count !== 3'd1 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin mismatched++; $display("FAIL simul_empty got c%0d u%b o%b want c1 u1 o0", bus.count, bus.underflow, bus.overflow); end
`ifdef FIFO_SYNC_FWFT_EN
      compared++; if (bus.read_data !== 8'h33) begin mismatched++; $display("FAIL simul_empty_data got %h want 33", bus.read_data); end
`else
      compared++; if (bus.read_data !== 8'h00) begin mismatched++; $display("FAIL simul_empty_hold got %h want 00", bus.read_data); end
      drive(0, 8'h00, 1);
      tick();
      compared++; if (bus.read_data !== 8'h33 || bus.count !== 3'd0) begin mismatched++; $display("FAIL simul_empty_pop got d%h c%0d want d33 c0", bus.read_data, bus.count); end
`endif
      drive(0, 8'h00, 0);
   endtask

`ifdef FIFO_SYNC_FWFT_EN
   task automatic test_fwft();
      rst = 1'b1;
      #1 rst = 1'b0;
      drive(1, 8'h5C, 0);
      compared++; if (bus.read_data !== 8'h00 || bus.read_empty !== 1'b1) begin mismatched++; $display("FAIL fwft_before got d%h e%b want d00 e1", bus.read_data, bus.read_empty); end
      tick();
      drive(0, 8'h00, 0);
      compared++; if (bus.read_data !== 8'h5C || bus.read_empty !== 1'b0) begin mismatched++; $display("FAIL fwft_fall got d%h e%b want d5C e0", bus.read_data, bus.read_empty); end
      tick();
      compared++; if (bus.read_data !== 8'h5C || bus.count !== 3'd1) begin mismatched++; $display("FAIL fwft_hold got d%h c%0d want d5C c1", bus.read_data, bus.count); end
      drive(0, 8'h00, 1);
      tick();
      drive(0, 8'h00, 0);
      compared++; if (bus.read_data !== 8'h00 || bus.read_empty !== 1'b1) begin mismatched++; $display("FAIL fwft_pop got d%h e%b want d00 e1", bus.read_data, bus.read_empty); end
   endtask
`endif

   initial begin
      drive(0, 8'h00, 0);
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
`ifdef FIFO_SYNC_FWFT_EN
      test_fwft();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
